data_ram_responder: RTL and testbench

//  Memory-side responder for the cache RAM interface (ram_read/ram_write/ram_addr/ram_wait).

---
 rtl/data_ram_responder_pkg.sv | 18 +
 rtl/data_ram_responder_rr_arbiter.sv | 40 ++++
 rtl/data_ram_responder.sv | 164 ++++++++++++++++
 tb/tb_data_ram_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder: bus widths, FSM encodings
// (reusable by cache-side models) and the latched access payload.
package data_ram_responder_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DATA_ADDR_W = 32;
    localparam int unsigned STATE_W     = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACK  = 2'd2;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
    } ram_acc_t;

endpackage

// File: rtl/data_ram_responder_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at/after ptr_i, or only the
// locked port while lock_i is asserted. Purely combinational one-hot grant.
module data_ram_responder_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    input  logic                 lock_i,
    input  logic [PTR_W-1:0]     lock_port_i,
    output logic [NUM_PORTS-1:0] grant_o_c
);

    int unsigned best_dist;
    int unsigned best_idx;
    logic        found;

    // Smallest rotational distance from the pointer wins.
    always_comb begin
        best_dist = NUM_PORTS;
        best_idx  = 0;
        found     = 1'b0;
        grant_o_c = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (req_i[j] && (((j + NUM_PORTS - 32'(ptr_i)) % NUM_PORTS) < best_dist)) begin
                best_dist = (j + NUM_PORTS - 32'(ptr_i)) % NUM_PORTS;
                best_idx  = j;
                found     = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (lock_i) begin
                grant_o_c[j] = req_i[j] && (j == 32'(lock_port_i));
            end else begin
                grant_o_c[j] = found && (j == best_idx);
            end
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder serving NUM_PORTS cache initiators from one word RAM,
// one access at a time: IDLE (arbitrate) -> BUSY (LATENCY cycles) -> ACK.
// Optional feature macro: RAM_ATOMIC_LOCK_EN (atomic grant locking).
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_ADDR_W-1:0] ram_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     ram_data_w,
    input  logic [NUM_PORTS-1:0]            ram_read,
    input  logic [NUM_PORTS-1:0]            ram_write,
    input  logic [NUM_PORTS-1:0]            ram_atomic,
    output logic [NUM_PORTS-1:0]            ram_wait,
    output logic [NUM_PORTS*DATA_W-1:0]     ram_data_r
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [STATE_W-1:0]          state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [PTR_W-1:0]            gidx_q, gidx_d;
    logic [ADDR_BITS-1:0]        addr_q, addr_d;
    ram_acc_t                    acc_q, acc_d;
    logic [NUM_PORTS-1:0]        wait_q, wait_d;
    logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_PORTS-1:0] req_c;
    logic [NUM_PORTS-1:0] grant_c;
    logic                 lock_eff_c;
    logic                 exec_c;
    logic                 unused_addr_hi;

    assign req_c          = ram_read | ram_write;
    assign exec_c         = (state_q == ST_BUSY) && (cnt_q == '0);
    assign unused_addr_hi = ^ram_addr;

`ifdef RAM_ATOMIC_LOCK_EN
    logic lock_q, lock_d;
    // Lock stays effective only while the owner keeps requesting atomically.
    assign lock_eff_c = lock_q && req_c[gidx_q] && ram_atomic[gidx_q];
`else
    logic unused_atomic;
    assign lock_eff_c    = 1'b0;
    assign unused_atomic = ^ram_atomic;
`endif

    data_ram_responder_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req_i       (req_c),
        .ptr_i       (ptr_q),
        .lock_i      (lock_eff_c),
        .lock_port_i (gidx_q),
        .grant_o_c   (grant_c)
    );

    // Next-state, access latching, ACK output and pointer/lock update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        wait_d  = '1;
        rdata_d = rdata_q;
`ifdef RAM_ATOMIC_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef RAM_ATOMIC_LOCK_EN
                lock_d = lock_eff_c;
`endif
                if (|grant_c) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                        if (grant_c[j]) begin
                            gidx_d     = PTR_W'(j);
                            addr_d     = ram_addr[j*DATA_ADDR_W +: ADDR_BITS];
                            acc_d.we   = ram_write[j];
                            acc_d.data = ram_data_w[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                        if (gidx_q == PTR_W'(j)) begin
                            wait_d[j] = 1'b0;
                            if (!acc_q.we) begin
                                rdata_d[j*DATA_W +: DATA_W] = mem[addr_q];
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                ptr_d   = (gidx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx_q + PTR_W'(1);
`ifdef RAM_ATOMIC_LOCK_EN
                lock_d  = ram_atomic[gidx_q];
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            wait_q  <= '1;
            rdata_q <= '0;
`ifdef RAM_ATOMIC_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
`ifdef RAM_ATOMIC_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    // RAM write port; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (rst_n && exec_c && acc_q.we) begin
            mem[addr_q] <= acc_q.data;
        end
    end

    assign ram_wait   = wait_q;
    assign ram_data_r = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized + directed bench for data_ram_responder with a transaction-level
// reference model (arbitration order, access age, RAM contents as a map).
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    localparam int NP  = 2;
    localparam int AB  = 12;
    localparam int LAT = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NP*DATA_ADDR_W-1:0] ram_addr;
    logic [NP*DATA_W-1:0]    ram_data_w;
    logic [NP-1:0]           ram_read, ram_write, ram_atomic;
    logic [NP-1:0]           ram_wait;
    logic [NP*DATA_W-1:0]    ram_data_r;

    always #5 clk = ~clk;

    data_ram_responder #(.NUM_PORTS(NP), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_addr   (ram_addr),
        .ram_data_w (ram_data_w),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_atomic (ram_atomic),
        .ram_wait   (ram_wait),
        .ram_data_r (ram_data_r)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit            model_on = 1'b0;
    bit            m_busy;
    int            m_age, m_g, m_ptr, m_lport;
    bit            m_lock, m_we;
    int unsigned   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_mem [int unsigned];
    logic [NP-1:0] exp_wait;
    logic [31:0]   exp_data [NP];
    bit            exp_known [NP];

    task automatic model_step();
        logic [NP-1:0] req;
        int  g;
        bit  hold;
        if (!rst_n) begin
            model_on = 1'b1;
            m_busy   = 1'b0;
            m_ptr    = 0;
            m_lock   = 1'b0;
            m_lport  = 0;
            exp_wait = '1;
            for (int p = 0; p < NP; p++) begin
                exp_data[p]  = '0;
                exp_known[p] = 1'b1;
            end
            return;
        end
        if (!model_on) return;
        exp_wait = '1;
        req = ram_read | ram_write;
        if (m_busy) begin
            m_age++;
            if (m_age == LAT) begin
                exp_wait[m_g] = 1'b0;
                if (m_we) m_mem[m_addr] = m_wdata;
                else if (m_mem.exists(m_addr)) begin
                    exp_data[m_g]  = m_mem[m_addr];
                    exp_known[m_g] = 1'b1;
                end else exp_known[m_g] = 1'b0;
            end else if (m_age == LAT + 1) begin
                m_busy  = 1'b0;
                m_ptr   = (m_g + 1) % NP;
`ifdef RAM_ATOMIC_LOCK_EN
                m_lock  = ram_atomic[m_g];
                m_lport = m_g;
`endif
            end
        end else begin
            hold = m_lock && req[m_lport] && ram_atomic[m_lport];
            m_lock = hold;
            g = -1;
            if (hold) g = m_lport;
            else for (int k = 0; k < NP; k++) begin
                if (g < 0 && req[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
            end
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_g     = g;
                m_we    = ram_write[g];
                m_addr  = 32'((ram_addr >> (g * DATA_ADDR_W)) & ((64'd1 << AB) - 64'd1));
                m_wdata = 32'(ram_data_w >> (g * DATA_W));
            end
        end
    endtask

    // Single compare process: model advances on the edge, DUT checked 1 unit later.
    always @(posedge clk) begin
        model_step();
        #1;
        if (model_on) begin
            check("ram_wait", 64'(ram_wait), 64'(exp_wait));
            for (int p = 0; p < NP; p++) begin
                if (exp_known[p])
                    check($sformatf("ram_data_r[%0d]", p), 64'(ram_data_r[p*DATA_W +: DATA_W]), 64'(exp_data[p]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_port(input int p, input bit rd, input bit wr, input bit at,
                            input logic [31:0] addr, input logic [31:0] data);
        ram_read[p]   = rd;
        ram_write[p]  = wr;
        ram_atomic[p] = at;
        ram_addr[p*DATA_ADDR_W +: DATA_ADDR_W] = addr;
        ram_data_w[p*DATA_W +: DATA_W]         = data;
    endtask

    task automatic access(input int p, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, output int lat, output logic [31:0] rdata);
        bit got;
        @(negedge clk);
        set_port(p, rd, wr, 1'b0, addr, data);
        lat = -1;
        rdata = '0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #2;
            if (ram_wait[p] == 1'b0) begin
                got   = 1'b1;
                lat   = i;
                rdata = ram_data_r[p*DATA_W +: DATA_W];
            end
        end
        @(negedge clk);
        set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    int          lat;
    logic [31:0] rd;
    int          order [$];
    int          n0;

    initial begin
        rst_n = 1'b0;
        ram_addr = '0; ram_data_w = '0; ram_read = '0; ram_write = '0; ram_atomic = '0;

        // Reset behaviour
        repeat (2) @(posedge clk);
        #2;
        check("reset_wait", 64'(ram_wait), 64'h3);
        check("reset_data", 64'(ram_data_r), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("idle_wait", 64'(ram_wait), 64'h3);

        // Single-port write then read
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd);
        check("wr_latency", 64'(lat), 64'(LAT + 1));
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd);
        check("rd_latency", 64'(lat), 64'(LAT + 1));
        check("rd_data_10", 64'(rd), 64'hDEADBEEF);

        // Round-robin: pointer is 1 after two port-0 accesses
        order.delete();
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, 0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h11, 0);
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            @(posedge clk); #2;
            if (ram_wait != 2'b11) begin
                check("no_dual_ack", 64'(ram_wait[0] | ram_wait[1]), 64'h1);
                order.push_back(ram_wait[0] ? 1 : 0);
            end
        end
        @(negedge clk);
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        check("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_order[%0d]", i), 64'(order[i]), 64'((i % 2 == 0) ? 1 : 0));

        // Read+write in same cycle is a write
        access(1, 1'b1, 1'b1, 32'h20, 32'h5, lat, rd);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd);
        check("rdwr_data_20", 64'(rd), 64'h5);

        // Reset on the commit edge drops the write
        access(0, 1'b0, 1'b1, 32'h30, 32'h1, lat, rd);
        @(negedge clk);
        set_port(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h7);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_port(0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check("abort_no_ack", 64'(ram_wait), 64'h3);
        @(negedge clk) rst_n = 1'b1;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, rd);
        check("abort_prior_value", 64'(rd), 64'h1);

        // Atomic locking (port 1 access first makes the pointer 0)
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, lat, rd);
        order.delete();
        n0 = 0;
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h10, 0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h20, 0);
        for (int i = 0; i < 100 && order.size() < 4; i++) begin
            @(posedge clk); #2;
            if (ram_wait != 2'b11) begin
                order.push_back(ram_wait[0] ? 1 : 0);
                if (ram_wait[0] == 1'b0) n0++;
            end
            @(negedge clk);
            if (n0 >= 3) set_port(0, 0, 0, 0, 0, 0);
        end
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        check("atomic_count", 64'(order.size()), 64'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
`ifdef RAM_ATOMIC_LOCK_EN
            check($sformatf("atomic_order[%0d]", i), 64'(order[i]), 64'((i == 3) ? 1 : 0));
`else
            check($sformatf("atomic_order[%0d]", i), 64'(order[i]), 64'(i % 2));
`endif
        end

        // Random traffic against the model
        repeat (4) @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 79) != 0);
            for (int p = 0; p < NP; p++) begin
                set_port(p, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 1) == 1),
                         {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} & 32'hFFFF_F000
                             | 32'($urandom_range(0, 7)),
                         $urandom);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        ram_read = '0; ram_write = '0; ram_atomic = '0;
        repeat (10) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
